// File: rtl/time_of_day_counter_pkg.sv
// clock_pkg: mode encoding and field limits shared by the counter and display mux.
package clock_pkg;
    typedef enum logic [1:0] {MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN} clk_mode_e;
    localparam logic [4:0] MAX_HOUR = 5'd23;
    localparam logic [5:0] MAX_MIN  = 6'd59;
    localparam logic [5:0] MAX_SEC  = 6'd59;
endpackage

// File: rtl/time_of_day_counter_if.sv
// time_of_day_counter_if: button pulses in, time/mode/tick/blink out.
interface time_of_day_counter_if;
    import clock_pkg::*;
    logic       mode_btn;
    logic       inc_btn;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    clk_mode_e  mode;
    logic       sec_tick;
    logic       blink;
    modport slave (input mode_btn, inc_btn, output hour, min, sec, mode, sec_tick, blink);
    modport master (output mode_btn, inc_btn, input hour, min, sec, mode, sec_tick, blink);
endinterface

// File: rtl/time_of_day_counter_sec_prescaler.sv
// sec_prescaler: divides clk down to one wrap per second and a registered 1 Hz blink.
module sec_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_wrap,
    output logic o_blink
);
    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
    localparam logic [W-1:0] HALF = W'(TICK_DIV / 2);
    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_next;
    logic         r_blink;
    assign o_wrap     = r_cnt == LAST;
    assign w_cnt_next = (i_clr || o_wrap) ? '0 : r_cnt + W'(1);
    assign o_blink    = r_blink;
    // blink is registered from the next count so it always matches the current count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_blink <= 1'b1;
        end else begin
            r_cnt   <= w_cnt_next;
            r_blink <= w_cnt_next < HALF;
        end
    end
endmodule

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: 24-hour hh:mm:ss counter with RUN/SET_HOUR/SET_MIN setting modes.
module time_of_day_counter
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    time_of_day_counter_if.slave tod
);
    clk_mode_e  r_mode;
    clk_mode_e  w_mode_next;
    logic [4:0] r_hour;
    logic [5:0] r_min;
    logic [5:0] r_sec;
    logic       r_sec_tick;
    logic       w_wrap;
    logic       w_blink;
    logic       w_tick;
    logic       w_clr;
    logic       w_inc;
    sec_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .o_wrap  (w_wrap),
        .o_blink (w_blink)
    );
    assign w_tick = w_wrap && r_mode == MODE_RUN;
    assign w_clr  = tod.mode_btn && r_mode == MODE_SET_MIN;
    assign w_inc  = tod.inc_btn && !tod.mode_btn;
    always_comb begin
        w_mode_next = r_mode;
        if (tod.mode_btn)
            w_mode_next = r_mode == MODE_RUN      ? MODE_SET_HOUR :
                          r_mode == MODE_SET_HOUR ? MODE_SET_MIN  : MODE_RUN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= MODE_RUN;
            r_hour     <= '0;
            r_min      <= '0;
            r_sec      <= '0;
            r_sec_tick <= 1'b0;
        end else begin
            r_mode     <= w_mode_next;
            r_sec_tick <= w_tick;
            // a tick always lands, even if the mode changes on the same edge
            if (w_tick) begin
                r_sec <= r_sec == MAX_SEC ? '0 : r_sec + 6'd1;
                if (r_sec == MAX_SEC) begin
                    r_min <= r_min == MAX_MIN ? '0 : r_min + 6'd1;
                    if (r_min == MAX_MIN)
                        r_hour <= r_hour == MAX_HOUR ? '0 : r_hour + 5'd1;
                end
            end else if (w_clr) begin
                r_sec <= '0;
            end else if (w_inc && r_mode == MODE_SET_HOUR) begin
                r_hour <= r_hour == MAX_HOUR ? '0 : r_hour + 5'd1;
            end else if (w_inc && r_mode == MODE_SET_MIN) begin
                r_min <= r_min == MAX_MIN ? '0 : r_min + 6'd1;
            end
        end
    end
    assign tod.hour     = r_hour;
    assign tod.min      = r_min;
    assign tod.sec      = r_sec;
    assign tod.mode     = r_mode;
    assign tod.sec_tick = r_sec_tick;
    assign tod.blink    = w_blink;
endmodule

// File: tb/tb_time_of_day_counter.sv
// tb_time_of_day_counter: table-driven vectors plus directed corner-case sequences, TICK_DIV=4.
module tb_time_of_day_counter;
    import clock_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_tick;
    time_of_day_counter_if tod();
    time_of_day_counter #(.TICK_DIV(4)) dut (.clk(clk), .rst_n(rst_n), .tod(tod));
    always #5 clk = ~clk;
    typedef struct {
        logic       mb;
        logic       ib;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] md;
        logic       tk;
        logic       bl;
    } vec_t;
    vec_t tbl[18];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse(input logic mb, input logic ib);
        tod.mode_btn = mb;
        tod.inc_btn  = ib;
        cyc();
        tod.mode_btn = 1'b0;
        tod.inc_btn  = 1'b0;
    endtask
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            if (tod.sec_tick) n_tick++;
        end
    endtask
    initial begin
        tbl[0]  = '{0, 0, 5'd0, 6'd0, 6'd0, 2'd0, 0, 1};
        tbl[1]  = '{0, 1, 5'd0, 6'd0, 6'd0, 2'd0, 0, 0};
        tbl[2]  = '{0, 0, 5'd0, 6'd0, 6'd0, 2'd0, 0, 0};
        tbl[3]  = '{0, 0, 5'd0, 6'd0, 6'd1, 2'd0, 1, 1};
        tbl[4]  = '{0, 0, 5'd0, 6'd0, 6'd1, 2'd0, 0, 1};
        tbl[5]  = '{0, 0, 5'd0, 6'd0, 6'd1, 2'd0, 0, 0};
        tbl[6]  = '{0, 0, 5'd0, 6'd0, 6'd1, 2'd0, 0, 0};
        tbl[7]  = '{1, 0, 5'd0, 6'd0, 6'd2, 2'd1, 1, 1};
        tbl[8]  = '{0, 1, 5'd1, 6'd0, 6'd2, 2'd1, 0, 1};
        tbl[9]  = '{0, 1, 5'd2, 6'd0, 6'd2, 2'd1, 0, 0};
        tbl[10] = '{1, 1, 5'd2, 6'd0, 6'd2, 2'd2, 0, 0};
        tbl[11] = '{0, 1, 5'd2, 6'd1, 6'd2, 2'd2, 0, 1};
        tbl[12] = '{0, 1, 5'd2, 6'd2, 6'd2, 2'd2, 0, 1};
        tbl[13] = '{1, 0, 5'd2, 6'd2, 6'd0, 2'd0, 0, 1};
        tbl[14] = '{0, 0, 5'd2, 6'd2, 6'd0, 2'd0, 0, 1};
        tbl[15] = '{0, 0, 5'd2, 6'd2, 6'd0, 2'd0, 0, 0};
        tbl[16] = '{0, 0, 5'd2, 6'd2, 6'd0, 2'd0, 0, 0};
        tbl[17] = '{0, 0, 5'd2, 6'd2, 6'd1, 2'd0, 1, 1};
        tod.mode_btn = 1'b0;
        tod.inc_btn  = 1'b0;
        #12;
        chk("reset_state", {tod.hour, tod.min, tod.sec, 2'(tod.mode), tod.sec_tick, tod.blink},
            {5'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 18; i++) begin
            pulse(tbl[i].mb, tbl[i].ib);
            chk($sformatf("vec%0d", i),
                {tod.hour, tod.min, tod.sec, 2'(tod.mode), tod.sec_tick, tod.blink},
                {tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].md, tbl[i].tk, tbl[i].bl});
        end
        // async reset just after a tick edge, while sec_tick is high
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {tod.hour, tod.min, tod.sec, 2'(tod.mode), tod.sec_tick, tod.blink},
            {5'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b1});
        cyc();
        chk("reset_hold_tick", 32'(tod.sec_tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // preload 23:59:58 then watch the full carry
        pulse(1, 0);
        for (int i = 0; i < 23; i++) pulse(0, 1);
        pulse(1, 0);
        for (int i = 0; i < 59; i++) pulse(0, 1);
        pulse(1, 0);
        chk("preload_hm", {tod.hour, tod.min, 2'(tod.mode)}, {5'd23, 6'd59, 2'd0});
        run(232);
        chk("preload_sec", {tod.hour, tod.min, tod.sec}, {5'd23, 6'd59, 6'd58});
        n_tick = 0;
        run(4);
        chk("carry_59", {tod.hour, tod.min, tod.sec, tod.sec_tick}, {5'd23, 6'd59, 6'd59, 1'b1});
        run(4);
        chk("carry_wrap", {tod.hour, tod.min, tod.sec, tod.sec_tick}, {5'd0, 6'd0, 6'd0, 1'b1});
        chk("carry_ticks", 32'(n_tick), 32'd2);
        run(5);
        chk("pre_hour_sec", 32'(tod.sec), 32'd1);
        pulse(1, 0);
        n_tick = 0;
        for (int i = 0; i < 25; i++) begin
            pulse(0, 1);
            if (tod.sec_tick) n_tick++;
        end
        run(6);
        chk("hour_wrap", {tod.hour, tod.min, tod.sec, 2'(tod.mode)}, {5'd1, 6'd0, 6'd1, 2'd1});
        chk("set_no_tick", 32'(n_tick), 32'd0);
        pulse(1, 0);
        for (int i = 0; i < 59; i++) pulse(0, 1);
        chk("min_59", {tod.hour, tod.min}, {5'd1, 6'd59});
        pulse(0, 1);
        chk("min_wrap", {tod.hour, tod.min, 2'(tod.mode)}, {5'd1, 6'd0, 2'd2});
        pulse(1, 0);
        run(148);
        chk("run_sec37", {tod.sec, 2'(tod.mode)}, {6'd37, 2'd0});
        pulse(1, 0);
        pulse(1, 0);
        run(3);
        chk("frozen_37", {tod.sec, 2'(tod.mode)}, {6'd37, 2'd2});
        pulse(1, 0);
        chk("exit_set", {tod.sec, 2'(tod.mode), tod.sec_tick}, {6'd0, 2'd0, 1'b0});
        n_tick = 0;
        run(3);
        chk("exit_no_early_tick", 32'(n_tick), 32'd0);
        run(1);
        chk("exit_first_tick", {tod.sec, tod.sec_tick}, {6'd1, 1'b1});
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
